// File: rtl/expr_resp_misr.sv
// ---------------------------------------------------------------------------
// expr_resp_misr
//
// Response compactor for the 90-bit result bus of an expression block. Over a
// run of a programmed number of vectors, every accepted result word is folded
// down to 32 bits and shifted into a multiple-input signature register (MISR).
// When the last vector is in, the signature is compared against a golden value
// captured at start, so regression only has to look at one pass/fail per run.
//
// Ports
//   clk        in   1      sole clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   start      in   1      run start pulse, honoured in IDLE or DONE only
//   num_vec    in   CNT_W  vectors in the run, captured on start
//   golden     in   SIG_W  expected signature, captured on start
//   y_valid    in   1      upstream word valid
//   y          in   Y_W    upstream result word
//   y_ready    out  1      word accepted this cycle when y_valid is high
//   busy       out  1      run in progress
//   done       out  1      run complete, pass is meaningful
//   pass       out  1      signature matches captured golden
//   signature  out  SIG_W  current MISR value
//   vec_count  out  CNT_W  words accepted in the current run
// ---------------------------------------------------------------------------
module expr_resp_misr #(
  parameter int               Y_W   = 90,
  parameter int               SIG_W = 32,
  parameter int               CNT_W = 16,
  parameter logic [SIG_W-1:0] POLY  = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SEED  = 32'hFFFFFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic [SIG_W-1:0] golden,
  input  logic             y_valid,
  input  logic [Y_W-1:0]   y,
  output logic             y_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] vec_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Three-way XOR fold of the result word: low word, middle word and the
  // zero-extended 26-bit top slice.
  function automatic logic [SIG_W-1:0] fold_word(input logic [Y_W-1:0] word);
    logic [SIG_W-1:0] lo;
    logic [SIG_W-1:0] mid;
    logic [SIG_W-1:0] hi;
    lo  = word[SIG_W-1:0];
    mid = word[2*SIG_W-1:SIG_W];
    hi  = SIG_W'(word[Y_W-1:2*SIG_W]);
    return lo ^ mid ^ hi;
  endfunction

  // One MISR step: shift left, feed back POLY when the MSB falls out, then
  // inject the folded word.
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                 input logic [SIG_W-1:0] fold);
    logic [SIG_W-1:0] fb;
    fb = sig[SIG_W-1] ? POLY : '0;
    return {sig[SIG_W-2:0], 1'b0} ^ fb ^ fold;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SIG_W-1:0] r_sig;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_num;
  logic [SIG_W-1:0] r_golden;

  logic             w_start_ok;
  logic             w_accept;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_last;
  logic [SIG_W-1:0] w_sig_nxt;

  // start only counts outside RUN; a pulse during a run is dropped entirely,
  // including its num_vec/golden values.
  assign w_start_ok = start && (r_state != S_RUN);
  assign w_accept   = (r_state == S_RUN) && y_valid;
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_last     = w_accept && (w_cnt_inc == r_num);
  assign w_sig_nxt  = misr_step(r_sig, fold_word(y));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = (num_vec == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // control and signature state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sig   <= SEED;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_ok) begin
        r_sig <= SEED;
        r_cnt <= '0;
      end else if (w_accept) begin
        r_sig <= w_sig_nxt;
        r_cnt <= w_cnt_inc;
      end
    end
  end

  // run parameters; only read once a start has loaded them, so no reset
  always_ff @(posedge clk) begin
    if (w_start_ok) begin
      r_num    <= num_vec;
      r_golden <= golden;
    end
  end

  // outputs decoded from registered state only
  assign y_ready   = (r_state == S_RUN);
  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign pass      = (r_state == S_DONE) && (r_sig == r_golden);
  assign signature = r_sig;
  assign vec_count = r_cnt;

endmodule

// File: tb/tb_expr_resp_misr.sv
module tb_expr_resp_misr;

  localparam logic [31:0] SEED = 32'hFFFFFFFF;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_vec = '0;
  logic [31:0] golden = '0;
  logic        y_valid = 1'b0;
  logic [89:0] y = '0;
  logic        y_ready;
  logic        busy;
  logic        done;
  logic        pass;
  logic [31:0] signature;
  logic [15:0] vec_count;

  int n_vec = 0;
  int n_err = 0;

  logic [89:0] ydata[$];
  logic [32:0] sb[$];  // {expected pass, expected signature}

  expr_resp_misr dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_vec   (num_vec),
    .golden    (golden),
    .y_valid   (y_valid),
    .y         (y),
    .y_ready   (y_ready),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .signature (signature),
    .vec_count (vec_count)
  );

  always #5 clk = ~clk;

  // Reference: fold bit i of the word onto signature bit i mod 32.
  function automatic logic [31:0] model_step(input logic [31:0] s, input logic [89:0] w);
    logic [31:0] f;
    logic [31:0] n;
    f = '0;
    for (int i = 0; i < 90; i++) f[i % 32] = f[i % 32] ^ w[i];
    n = s << 1;
    if (s[31]) n = n ^ POLY;
    return n ^ f;
  endfunction

  function automatic logic [89:0] rnd90();
    return 90'({$urandom(), $urandom(), $urandom()});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_y_ready"}, 32'(y_ready), 32'd0);
    chk({tag, "_busy"},    32'(busy),    32'd0);
    chk({tag, "_done"},    32'(done),    32'd0);
    chk({tag, "_pass"},    32'(pass),    32'd0);
    chk({tag, "_sig"},     signature,    SEED);
    chk({tag, "_cnt"},     32'(vec_count), 32'd0);
  endtask

  // Drives a full run over ydata[0..n-1]; optional y_valid toggling and
  // start pulses during the run (including on the final beat).
  task automatic do_run(input int n, input logic [31:0] gold_in, input bit gold_model,
                        input bit toggle, input bit restart);
    logic [31:0] m;
    logic [31:0] gold;
    logic [32:0] e;
    int acc;
    int cyc;
    bit v;
    m = SEED;
    for (int i = 0; i < n; i++) m = model_step(m, ydata[i]);
    gold = gold_model ? m : gold_in;
    start = 1'b1; num_vec = 16'(n); golden = gold;
    y_valid = 1'b1; y = rnd90();
    tick();
    start = 1'b0; num_vec = 16'($urandom()); golden = $urandom();
    chk("start_sig", signature, SEED);
    chk("start_cnt", 32'(vec_count), 32'd0);
    if (n == 0) begin
      sb.push_back({SEED == gold, SEED});
    end else begin
      chk("start_busy",  32'(busy),    32'd1);
      chk("start_ready", 32'(y_ready), 32'd1);
      chk("start_done",  32'(done),    32'd0);
    end
    acc = 0; cyc = 0;
    while (acc < n && cyc < 200) begin
      v = toggle ? (cyc % 2 == 0) : 1'b1;
      y_valid = v;
      y = v ? ydata[acc] : rnd90();
      if (restart && v && (acc == 2 || acc == n - 1)) begin
        start = 1'b1; num_vec = 16'd1; golden = ~gold;
      end
      tick();
      start = 1'b0;
      if (v) acc++;
      chk("beat_cnt", 32'(vec_count), 32'(acc));
      cyc++;
    end
    if (acc < n) chk("beat_timeout", 32'(acc), 32'(n));
    if (n > 0) sb.push_back({m == gold, m});
    y_valid = 1'b0;
    chk("end_done",  32'(done),    32'd1);
    chk("end_busy",  32'(busy),    32'd0);
    chk("end_ready", 32'(y_ready), 32'd0);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("end_sig",  signature,  e[31:0]);
      chk("end_pass", 32'(pass),  32'(e[32]));
    end
  endtask

  initial begin
    // asynchronous reset, observed before any clock edge
    #2 rst = 1'b1;
    #1 chk_idle_outputs("reset");
    tick(); tick();
    rst = 1'b0;
    tick();

    // words offered in IDLE are ignored
    y_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      y = rnd90();
      tick();
    end
    chk_idle_outputs("idle_offer");
    y_valid = 1'b0;

    // single zero word
    ydata = '{90'd0};
    do_run(1, 32'hFB3EE249, 1'b0, 1'b0, 1'b0);
    chk("zero_sig_const", signature, 32'hFB3EE249);
    chk("zero_pass_const", 32'(pass), 32'd1);

    // top slice bit 64 lands on signature bit 0
    ydata = '{90'd1 << 64};
    do_run(1, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("bit64_sig_const", signature, 32'hFB3EE248);

    // bits 0 and 32 cancel in the fold
    ydata = '{(90'd1 << 32) | 90'd1};
    do_run(1, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("cancel_sig_const", signature, 32'hFB3EE249);

    // bits 0, 32 and 64: odd count, bit 0 survives
    ydata = '{(90'd1 << 64) | (90'd1 << 32) | 90'd1};
    do_run(1, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("three_sig_const", signature, 32'hFB3EE248);

    // zero-length run
    ydata = '{};
    do_run(0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    chk("zero_len_pass", 32'(pass), 32'd1);

    // 5 beats, stalls, start pulses mid-run and on the last beat
    ydata = '{};
    for (int i = 0; i < 5; i++) ydata.push_back(rnd90());
    do_run(5, 32'd0, 1'b1, 1'b1, 1'b1);
    chk("five_pass", 32'(pass), 32'd1);
    do_run(5, 32'h12345678, 1'b0, 1'b1, 1'b0);

    // reset after 3 of 5 beats
    ydata = '{};
    for (int i = 0; i < 5; i++) ydata.push_back(rnd90());
    start = 1'b1; num_vec = 16'd5; golden = 32'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      y_valid = 1'b1; y = ydata[i];
      tick();
    end
    y_valid = 1'b0;
    chk("pre_rst_cnt", 32'(vec_count), 32'd3);
    rst = 1'b1;
    #1 chk_idle_outputs("mid_rst");
    tick();
    rst = 1'b0;
    tick();
    chk_idle_outputs("post_rst");
    do_run(5, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("after_rst_pass", 32'(pass), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
